// File: rtl/inverse_clarke_pkg.sv
// Shared constants and helpers for the fixed-point inverse Clarke transform.
package inverse_clarke_pkg;

    // Integer square root (floor) by bitwise binary search.
    function automatic int unsigned isqrt64(input longint unsigned n);
        longint unsigned r;
        longint unsigned t;
        r = 64'd0;
        for (int i = 31; i >= 0; i--) begin
            t = r | (64'd1 << i);
            if (t * t <= n) r = t;
        end
        return r[31:0];
    endfunction

    // round(sqrt(3)/2 * 2^q) == (floor(sqrt(3 * 4^q)) + 1) >> 1
    function automatic int unsigned k_const(input int q);
        return (isqrt64(64'd3 << (2 * q)) + 32'd1) >> 1;
    endfunction

    function automatic int int_width(input int d, input int q);
        return d + q + 2;
    endfunction

    function automatic logic signed [63:0] sat_max(input int d);
        return (64'sd1 <<< (d - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int d);
        return -(64'sd1 <<< (d - 1));
    endfunction

endpackage

// File: rtl/inverse_clarke_if.sv
// Sample stream interface: alpha/beta in with valid, a/b/c out with valid.
interface inverse_clarke_if #(
    parameter int D_WIDTH = 32
) ();
    logic                      in_valid;
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      out_valid;
    logic signed [D_WIDTH-1:0] a;
    logic signed [D_WIDTH-1:0] b;
    logic signed [D_WIDTH-1:0] c;

    modport master (
        output in_valid, alpha, beta,
        input  out_valid, a, b, c
    );

    modport slave (
        input  in_valid, alpha, beta,
        output out_valid, a, b, c
    );
endinterface

// File: rtl/inverse_clarke_sat.sv
// Wide-to-D_WIDTH signed narrower; saturates when INVERSE_CLARKE_SAT_EN is
// defined, otherwise wraps in two's complement. Requires W_WIDTH <= 64.
module inverse_clarke_sat
    import inverse_clarke_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int W_WIDTH = 44
) (
    input  logic signed [W_WIDTH-1:0] din,
    output logic signed [D_WIDTH-1:0] dout
);

`ifdef INVERSE_CLARKE_SAT_EN
    localparam logic signed [63:0]        MAX64 = sat_max(D_WIDTH);
    localparam logic signed [63:0]        MIN64 = sat_min(D_WIDTH);
    localparam logic signed [W_WIDTH-1:0] MAXW  = MAX64[W_WIDTH-1:0];
    localparam logic signed [W_WIDTH-1:0] MINW  = MIN64[W_WIDTH-1:0];

    always_comb begin
        dout = din[D_WIDTH-1:0];
        if (din > MAXW) begin
            dout = MAXW[D_WIDTH-1:0];
        end else if (din < MINW) begin
            dout = MINW[D_WIDTH-1:0];
        end
    end
`else
    logic unused_hi;

    assign dout      = din[D_WIDTH-1:0];
    assign unused_hi = ^din[W_WIDTH-1:D_WIDTH];
`endif

endmodule

// File: rtl/inverse_clarke_fx.sv
// Two-stage fixed-point inverse Clarke transform (alpha, beta) -> (a, b, c).
// Output saturation of b/c is enabled by defining INVERSE_CLARKE_SAT_EN.
module inverse_clarke_fx
    import inverse_clarke_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10
) (
    input logic           clk,
    input logic           rst,
    inverse_clarke_if.slave bus
);

    localparam int W = int_width(D_WIDTH, Q_BITS);
    localparam logic signed [W-1:0] K_W = W'(k_const(Q_BITS));
    localparam logic signed [W-1:0] RND = W'(64'd1 << (Q_BITS - 1));

    logic signed [W-1:0]       beta_w;
    logic signed [W-1:0]       prod_w;
    logic signed [W-1:0]       p_w;
    logic signed [D_WIDTH-1:0] half_d;

    logic                      s1_valid;
    logic signed [D_WIDTH-1:0] s1_alpha;
    logic signed [D_WIDTH-1:0] s1_half;
    logic signed [W-1:0]       s1_p;

    logic signed [W-1:0]       half_w;
    logic signed [W-1:0]       b_w;
    logic signed [W-1:0]       c_w;
    logic signed [D_WIDTH-1:0] b_n;
    logic signed [D_WIDTH-1:0] c_n;

    logic                      out_valid_r;
    logic signed [D_WIDTH-1:0] a_r;
    logic signed [D_WIDTH-1:0] b_r;
    logic signed [D_WIDTH-1:0] c_r;

    // Stage 1 math: the product needs at most D_WIDTH+Q_BITS+1 bits, so W never wraps.
    assign beta_w = {{(W - D_WIDTH){bus.beta[D_WIDTH-1]}}, bus.beta};
    assign prod_w = beta_w * K_W;
    assign p_w    = (prod_w + RND) >>> Q_BITS;
    assign half_d = bus.alpha >>> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_alpha <= bus.alpha;
                s1_half  <= half_d;
                s1_p     <= p_w;
            end
        end
    end

    assign half_w = {{(W - D_WIDTH){s1_half[D_WIDTH-1]}}, s1_half};
    assign b_w    = s1_p - half_w;
    assign c_w    = -(half_w + s1_p);

    inverse_clarke_sat #(.D_WIDTH(D_WIDTH), .W_WIDTH(W)) u_sat_b (
        .din  (b_w),
        .dout (b_n)
    );

    inverse_clarke_sat #(.D_WIDTH(D_WIDTH), .W_WIDTH(W)) u_sat_c (
        .din  (c_w),
        .dout (c_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= '0;
        end else begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                a_r <= s1_alpha;
                b_r <= b_n;
                c_r <= c_n;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.a         = a_r;
    assign bus.b         = b_r;
    assign bus.c         = c_r;

endmodule

// File: tb/tb_inverse_clarke_fx.sv
// Bench for inverse_clarke_fx: directed vectors, reset mid-stream, overflow and
// random samples against a timestamped expectation queue built from plain arithmetic.
module tb_inverse_clarke_fx;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    longint k_model;

    typedef struct {
        int due;
        int ea;
        int eb;
        int ec;
    } exp_t;

    exp_t q[$];

    inverse_clarke_if #(.D_WIDTH(32)) bus ();

    inverse_clarke_fx #(.D_WIDTH(32), .Q_BITS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int narrow(input longint v);
`ifdef INVERSE_CLARKE_SAT_EN
        if (v > 64'sd2147483647) return 32'h7fffffff;
        if (v < -64'sd2147483648) return 32'h80000000;
`endif
        return int'(v);
    endfunction

    task automatic model(input int al, input int be, output int ea, output int eb, output int ec);
        longint h;
        longint p;
        h  = longint'(al) >>> 1;
        p  = (longint'(be) * k_model + 64'sd512) >>> 10;
        ea = al;
        eb = narrow(p - h);
        ec = narrow(-h - p);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, $signed(got), $signed(exp));
        end
    endtask

    // One clock: drive inputs, advance, then check outputs on the falling edge.
    task automatic step(input bit r, input bit v, input int al, input int be,
                        input bit use_exp, input int xa, input int xb, input int xc);
        exp_t e;
        rst          = r;
        bus.in_valid = v;
        bus.alpha    = al;
        bus.beta     = be;
        if (!r && v) begin
            e.due = cyc + 2;
            if (use_exp) begin
                e.ea = xa; e.eb = xb; e.ec = xc;
            end else begin
                model(al, be, e.ea, e.eb, e.ec);
            end
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        if (r) q.delete();
        @(negedge clk);
        if (r) begin
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_a", bus.a, 32'd0);
            chk("rst_b", bus.b, 32'd0);
            chk("rst_c", bus.c, 32'd0);
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("valid", 32'(bus.out_valid), 32'd1);
            chk("a", bus.a, e.ea);
            chk("b", bus.b, e.eb);
            chk("c", bus.c, e.ec);
        end else begin
            chk("idle_valid", 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        int al;
        int be;
        bit v;
        bit r;
        total   = 0;
        bad     = 0;
        cyc     = 0;
        k_model = longint'($sqrt(3.0) * 512.0);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.alpha    = '0;
        bus.beta     = '0;

        // Reset, including a sample offered during reset that must be ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 40, 32, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Directed vectors back-to-back.
        step(0, 1, 40, 32, 1, 40, 8, -48);
        step(0, 1, 32, 40, 1, 32, 19, -51);
        step(0, 1, -32, 40, 1, -32, 51, -19);
        step(0, 1, -32, -40, 1, -32, -19, 51);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with two samples in flight.
        step(0, 1, 100, 200, 0, 0, 0, 0);
        step(0, 1, -300, 77, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Overflow corner and extremes.
        step(0, 1, 32'h80000000, 32'h7fffffff, 0, 0, 0, 0);
        step(0, 1, 32'h7fffffff, 32'h80000000, 0, 0, 0, 0);
        step(0, 1, 32'h80000000, 32'h80000000, 0, 0, 0, 0);
        step(0, 1, -1, -1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with bubbles and occasional resets.
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 50) == 0);
            al = int'($urandom);
            be = int'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                al = int'($urandom_range(0, 4095)) - 2048;
                be = int'($urandom_range(0, 4095)) - 2048;
            end
            step(r, v, al, be, 0, 0, 0, 0);
        end
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

        chk("drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
